// File: rtl/instruction_fetch_unit_if.sv
// Fetch-stage bundle: instruction-memory handshake, downstream control inputs and the
// fetched instruction presented to decode.
interface instruction_fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_offset;
  logic [31:0] instr;
  logic [5:0]  opcode;
  logic        instr_valid;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic [31:0] retire_count;

  modport master (
    output imem_req, imem_addr, instr, opcode, instr_valid, pc, pc_plus4, retire_count,
    input  imem_ready, imem_rdata, stall, branch_taken, branch_offset
  );

  modport slave (
    input  imem_req, imem_addr, instr, opcode, instr_valid, pc, pc_plus4, retire_count,
    output imem_ready, imem_rdata, stall, branch_taken, branch_offset
  );
endinterface

// File: rtl/instruction_fetch_unit.sv
// MIPS fetch stage: owns the PC, reads one word per instruction from instruction memory
// and holds it for decode until consumed, then steps sequentially or to a branch target.
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                      clk,
  input  logic                      reset,
  instruction_fetch_unit_if.master  bus
);

  typedef enum logic {S_REQ, S_VALID} state_t;

  state_t      state;
  logic [31:0] pcReg;
  logic [31:0] instrReg;
  logic [31:0] retireCount;
  logic [31:0] pcPlus4;
  logic        consume;

  // Word offset scaled to bytes; bits shifted past bit 31 are dropped by design.
  function automatic logic [31:0] branchTarget(input logic [31:0] seqPc,
                                               input logic [31:0] offset);
    return seqPc + (offset << 2);
  endfunction

  assign pcPlus4 = pcReg + 32'd4;
  assign consume = (state == S_VALID) && !bus.stall;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_REQ;
      pcReg       <= RESET_PC;
      instrReg    <= 32'h0;
      retireCount <= 32'h0;
    end else begin
      case (state)
        S_REQ: begin
          if (bus.imem_ready) begin
            instrReg <= bus.imem_rdata;
            state    <= S_VALID;
          end
        end
        S_VALID: begin
          if (consume) begin
            pcReg       <= bus.branch_taken ? branchTarget(pcPlus4, bus.branch_offset) : pcPlus4;
            retireCount <= retireCount + 32'd1;
            state       <= S_REQ;
          end
        end
        default: state <= S_REQ;
      endcase
    end
  end

  // A request is never shown to memory while reset is held, even for one cycle.
  assign bus.imem_req     = (state == S_REQ) && !reset;
  assign bus.imem_addr    = pcReg;
  assign bus.instr        = instrReg;
  assign bus.instr_valid  = (state == S_VALID);
  // All-ones opcode decodes to the control unit's inert default, making bubbles harmless.
  assign bus.opcode       = (state == S_VALID) ? instrReg[31:26] : 6'b111111;
  assign bus.pc           = pcReg;
  assign bus.pc_plus4     = pcPlus4;
  assign bus.retire_count = retireCount;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Randomized scoreboard bench for instruction_fetch_unit: driver pushes delivered words,
// monitor tracks PC/retire count from the fetch rules and compares every cycle.
module tb_instruction_fetch_unit;

  logic clk;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  logic [31:0] sbq[$];

  instruction_fetch_unit_if bus();
  instruction_fetch_unit_if bus2();

  instruction_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  instruction_fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dutWrap (
    .clk(clk), .reset(reset), .bus(bus2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic randomIgnored();
    bus.branch_taken  = 1'($urandom);
    bus.branch_offset = $urandom;
  endtask

  // One instruction: wait states, delivery, stall cycles, then the consume cycle.
  task automatic doInstr(input int delay, input logic [31:0] word, input int stalls,
                         input bit taken, input logic [31:0] off);
    for (int i = 0; i < delay; i++) begin
      bus.imem_ready = 1'b0;
      bus.imem_rdata = $urandom;
      bus.stall      = 1'($urandom);
      randomIgnored();
      cyc();
    end
    bus.imem_ready = 1'b1;
    bus.imem_rdata = word;
    bus.stall      = 1'($urandom);
    randomIgnored();
    sbq.push_back(word);
    cyc();
    for (int i = 0; i < stalls; i++) begin
      bus.imem_ready = 1'($urandom);
      bus.imem_rdata = $urandom;
      bus.stall      = 1'b1;
      randomIgnored();
      cyc();
    end
    bus.imem_ready    = 1'($urandom);
    bus.imem_rdata    = $urandom;
    bus.stall         = 1'b0;
    bus.branch_taken  = taken;
    bus.branch_offset = off;
    cyc();
    bus.imem_ready = 1'b0;
  endtask

  // Monitor: reference model of the fetch rules at transaction level.
  initial begin
    logic [31:0] mPc;
    logic [31:0] mCnt;
    bit          expValid;
    mPc = 32'h0; mCnt = 32'h0; expValid = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        chk("req_in_reset", {31'h0, bus.imem_req}, 32'h0);
        expValid = 1'b0;
        mPc      = 32'h0;
        mCnt     = 32'h0;
        sbq.delete();
      end else begin
        chk("instr_valid", {31'h0, bus.instr_valid}, {31'h0, expValid});
        chk("pc", bus.pc, mPc);
        chk("pc_plus4", bus.pc_plus4, mPc + 32'd4);
        chk("retire_count", bus.retire_count, mCnt);
        if (!expValid) begin
          chk("req_in_s_req", {31'h0, bus.imem_req}, 32'h1);
          chk("imem_addr", bus.imem_addr, mPc);
          chk("bubble_opcode", {26'h0, bus.opcode}, 32'h3F);
          if (bus.imem_ready) expValid = 1'b1;
        end else begin
          chk("req_in_s_valid", {31'h0, bus.imem_req}, 32'h0);
          if (sbq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_underflow actual=empty expected=pending_word");
          end else begin
            chk("instr", bus.instr, sbq[0]);
            chk("opcode", {26'h0, bus.opcode}, {26'h0, sbq[0][31:26]});
          end
          if (!bus.stall) begin
            if (sbq.size() != 0) void'(sbq.pop_front());
            mPc      = bus.branch_taken ? mPc + 32'd4 + (bus.branch_offset << 2) : mPc + 32'd4;
            mCnt     = mCnt + 32'd1;
            expValid = 1'b0;
          end
        end
      end
    end
  end

  // PC wrap at the top of the address space, on the second instance.
  initial begin
    bus2.imem_ready    = 1'b1;
    bus2.imem_rdata    = 32'h2008_0001;
    bus2.stall         = 1'b0;
    bus2.branch_taken  = 1'b0;
    bus2.branch_offset = 32'h0;
    @(negedge reset);
    @(negedge clk);
    chk("wrap_reset_pc", bus2.pc, 32'hFFFF_FFFC);
    chk("wrap_pc_plus4", bus2.pc_plus4, 32'h0);
    @(negedge clk);
    chk("wrap_valid", {31'h0, bus2.instr_valid}, 32'h1);
    @(negedge clk);
    chk("wrap_pc", bus2.pc, 32'h0);
    chk("wrap_addr", bus2.imem_addr, 32'h0);
    chk("wrap_req", {31'h0, bus2.imem_req}, 32'h1);
  end

  initial begin
    logic [31:0] off;
    int          s;
    reset             = 1'b1;
    bus.imem_ready    = 1'b0;
    bus.imem_rdata    = 32'h0;
    bus.stall         = 1'b0;
    bus.branch_taken  = 1'b0;
    bus.branch_offset = 32'h0;
    repeat (3) cyc();
    reset = 1'b0;

    // Directed: immediate delivery, delayed ready, stalls, backward-by-one branch.
    doInstr(0, 32'h8C08_0004, 0, 1'b0, 32'h0);
    doInstr(3, 32'h0109_5020, 2, 1'b0, 32'h0);
    doInstr(1, 32'h1000_FFFF, 0, 1'b1, 32'hFFFF_FFFF);
    doInstr(0, 32'hAC0A_0008, 1, 1'b0, 32'h0);

    // Reset during S_REQ with ready high: response ignored.
    bus.imem_ready = 1'b1;
    bus.imem_rdata = 32'hDEAD_BEEF;
    reset          = 1'b1;
    cyc();
    reset          = 1'b0;
    bus.imem_ready = 1'b0;
    doInstr(0, 32'h1000_0003, 0, 1'b1, 32'h3);

    // Reset dominating a consume cycle.
    bus.imem_ready = 1'b1;
    bus.imem_rdata = 32'h2129_0001;
    bus.stall      = 1'b0;
    sbq.push_back(32'h2129_0001);
    cyc();
    bus.imem_ready    = 1'b0;
    bus.branch_taken  = 1'b1;
    bus.branch_offset = 32'h5;
    reset             = 1'b1;
    cyc();
    reset = 1'b0;

    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 1) == 1) begin
        off = $urandom;
      end else begin
        s   = int'($urandom_range(0, 15)) - 8;
        off = 32'(s);
      end
      doInstr(int'($urandom_range(0, 3)), $urandom, int'($urandom_range(0, 2)),
              1'($urandom), off);
    end

    bus.stall = 1'b0;
    repeat (3) cyc();
    chk("sb_drained", 32'(sbq.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
